gray_ptr_wr: RTL and testbench
==============================

GRAY_PTR_WR -- requirements
Module: gray_ptr_wr

Interface
REQ-001: Parameter p_addr_width, default 3, FIFO address width; depth = 2^p_addr_width; legal range 1..16.
REQ-002: Local pointer width PW = p_addr_width+1 (one wrap bit above the address).
REQ-003: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset; acts immediately, independent of clk.
REQ-005: w_en  input  1  write request from the producer.
REQ-006: rptr_gray  input  PW  read-side Gray pointer from the foreign domain; treated as asynchronous.
REQ-007: w_accept  output  1  combinational; high when a write is accepted this cycle.
REQ-008: waddr  output  p_addr_width  binary RAM write address.
REQ-009: wptr_gray  output  PW  registered Gray write pointer, exported to the read domain.
REQ-010: full  output  1  registered full flag.
REQ-011: wlevel  output  PW  registered occupancy, as seen by the write side, range 0..depth.

Function
REQ-012: w_accept SHALL equal w_en & ~full; a write while full is dropped with no state change.
REQ-013: The block SHALL hold a PW-bit binary pointer wbin; waddr SHALL equal wbin[p_addr_width-1:0].
REQ-014: On an accepted write, wbin SHALL increment modulo 2^PW, with 2^PW-1 wrapping to 0.
REQ-015: Define wbin_next = wbin+1 when w_accept, else wbin.
REQ-016: wptr_gray SHALL register wbin_next ^ (wbin_next >> 1) every cycle.
- wptr_gray always equals the Gray code of wbin.
- wptr_gray never changes in more than one bit per cycle.
REQ-017: rptr_gray SHALL pass through a 2-flop synchronizer (rq1 <= rptr_gray, rq2 <= rq1).
- No logic is permitted between the two flops.
REQ-018: Define rbin_sync as the Gray-to-binary conversion of rq2, where bit i is the XOR of rq2 bits i..PW-1.
REQ-019: full SHALL register (wptr_gray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]}), where wptr_gray_next is the value defined in REQ-016.
- When PW = 2, the comparison is against ~rq2.
REQ-020: wlevel SHALL register (wbin_next - rbin_sync) mod 2^PW.
REQ-021: full SHALL be high iff wlevel == depth; this equivalence is an assertion the bench checks every cycle.
REQ-022: Latency:
- w_accept to updated waddr / wptr_gray / wlevel / full: 1 cycle.
- rptr_gray change to full / wlevel update: 3 rising edges (2 synchronizer + 1 flag register).
REQ-023: Same-cycle w_en and rptr_gray advance while full:
- The write is rejected that cycle, since full is registered.
- The freed slot becomes writable only after full falls.
REQ-024: full is pessimistic.
- It SHALL NOT deassert earlier than REQ-022 allows.
- It SHALL never permit wlevel to exceed depth.

Reset
REQ-025: While reset is high, wbin, wptr_gray, rq1, rq2, full and wlevel SHALL be 0, and waddr SHALL be 0.
REQ-026: Reset asserted mid-operation, including while full, SHALL clear all state without a clock edge.
REQ-027: After reset deasserts, the first accepted write SHALL go to waddr 0.
REQ-028: w_accept SHALL be w_en & ~full at all times; during reset it equals w_en, and no state updates until reset deasserts.

Verification
REQ-029: Fill: p_addr_width=3, rptr_gray held at 0, 8 cycles of w_en=1 ->
- waddr steps 0..7.
- After the 8th write: wptr_gray=4'b1100, wlevel=8, full=1.
REQ-030: Overflow: one more w_en=1 while full -> w_accept=0; waddr, wptr_gray and wlevel unchanged.
REQ-031: Drain: from full, rptr_gray set to 4'b0001 -> full=0 and wlevel=7 at the 3rd rising edge after the change, not before.
REQ-032: Wrap: 16 accepted writes with rptr_gray tracking wptr_gray two cycles behind ->
- wptr_gray follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
- Exactly one bit changes per step.
- full is never asserted.
REQ-033: Async reset: assert reset between clock edges while full=1 and wlevel=8 -> all outputs 0 before the next edge; the next write lands at waddr 0.
REQ-034: Simultaneous: full=1, w_en=1 held while rptr_gray advances one step ->
- w_accept=0 for 3 cycles.
- w_accept=1 on the cycle full falls; full re-asserts 1 cycle later.

Source files
------------

// File: rtl/gray_ptr_wr.sv
// rtl/gray_ptr_wr.sv - FIFO write-side pointer: binary/Gray write pointer, read pointer synchronizer, full flag and occupancy
module gray_ptr_wr #(
  parameter int p_addr_width = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    w_en,
  input  logic [p_addr_width:0]   rptr_gray,
  output logic                    w_accept,
  output logic [p_addr_width-1:0] waddr,
  output logic [p_addr_width:0]   wptr_gray,
  output logic                    full,
  output logic [p_addr_width:0]   wlevel
);

  localparam int PW = p_addr_width + 1;
  // Full when the write pointer is exactly one lap ahead: the top two Gray bits differ.
  localparam logic [PW-1:0] full_mask = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_gray_q, wptr_gray_d;
  logic [PW-1:0] rq1_q, rq2_q;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          full_q, full_d;

  assign w_accept = w_en & ~full_q;

  always_comb begin
    wbin_d = wbin_q;
    if (w_accept) begin
      wbin_d = wbin_q + PW'(1);
    end
    wptr_gray_d = wbin_d ^ (wbin_d >> 1);
  end

  // Gray to binary: bit i is the XOR of all synchronized bits at or above i.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_sync = rbin_sync ^ (rq2_q >> i);
    end
  end

  always_comb begin
    full_d   = (wptr_gray_d == (rq2_q ^ full_mask));
    wlevel_d = wbin_d - rbin_sync;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin_q      <= '0;
      wptr_gray_q <= '0;
      rq1_q       <= '0;
      rq2_q       <= '0;
      full_q      <= 1'b0;
      wlevel_q    <= '0;
    end else begin
      wbin_q      <= wbin_d;
      wptr_gray_q <= wptr_gray_d;
      rq1_q       <= rptr_gray;
      rq2_q       <= rq1_q;
      full_q      <= full_d;
      wlevel_q    <= wlevel_d;
    end
  end

  assign waddr     = wbin_q[p_addr_width-1:0];
  assign wptr_gray = wptr_gray_q;
  assign full      = full_q;
  assign wlevel    = wlevel_q;

endmodule

// File: tb/tb_gray_ptr_wr.sv
// tb/tb_gray_ptr_wr.sv - randomized self-checking bench for gray_ptr_wr against a count-based model
module tb_gray_ptr_wr;

  localparam int AW    = 3;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int MASK  = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_en;
  logic [PW-1:0] rptr_gray;
  logic          w_accept;
  logic [AW-1:0] waddr;
  logic [PW-1:0] wptr_gray;
  logic          full;
  logic [PW-1:0] wlevel;

  gray_ptr_wr #(.p_addr_width(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_en      (w_en),
    .rptr_gray (rptr_gray),
    .w_accept  (w_accept),
    .waddr     (waddr),
    .wptr_gray (wptr_gray),
    .full      (full),
    .wlevel    (wlevel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: total writes and the read count seen through a two-stage delay.
  int w_total;
  int r_total;
  int q1, q2;
  int m_level;
  bit m_full;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int b);
    int m;
    m = b & MASK;
    return PW'(m ^ (m >> 1));
  endfunction

  task automatic model_clear();
    w_total = 0;
    r_total = 0;
    q1      = 0;
    q2      = 0;
    m_level = 0;
    m_full  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_waddr"}, waddr, 0);
    check_eq({tag, "_wptr_gray"}, wptr_gray, 0);
    check_eq({tag, "_full"}, full, 0);
    check_eq({tag, "_wlevel"}, wlevel, 0);
  endtask

  task automatic cycle(input bit we, input int rb, output bit acc);
    w_en      = we;
    rptr_gray = to_gray(rb);
    #1;
    acc = we && !m_full;
    check_eq("w_accept", w_accept, acc);
    check_eq("waddr_pre", waddr, w_total % DEPTH);
    @(posedge clk);
    if (acc) w_total++;
    m_level = (w_total - q2) & MASK;
    m_full  = (m_level == DEPTH);
    q2 = q1;
    q1 = rb & MASK;
    #1;
    check_eq("wptr_gray", wptr_gray, to_gray(w_total));
    check_eq("wlevel", wlevel, m_level);
    check_eq("full", full, m_full);
  endtask

  task automatic fresh_reset();
    reset = 1'b1;
    #1;
    check_all_zero("rst");
    model_clear();
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) check_eq("full_iff_depth", full, wlevel == DEPTH);
  end

  bit acc;
  logic [PW-1:0] prev_g;
  logic [PW-1:0] wrap_seq [17];
  int prev1, prev2;

  initial begin
    wrap_seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    reset     = 1'b1;
    w_en      = 1'b0;
    rptr_gray = '0;
    model_clear();
    #1;
    check_all_zero("reset");
    w_en = 1'b1;
    #1;
    check_eq("accept_in_reset", w_accept, 1);
    @(posedge clk);
    #1;
    check_all_zero("reset_edge");
    reset = 1'b0;

    // Fill with the read pointer parked at zero.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 0, acc);
    end
    check_eq("fill_gray", wptr_gray, 4'b1100);
    check_eq("fill_level", wlevel, DEPTH);
    check_eq("fill_full", full, 1);

    // Overflow attempt is dropped.
    cycle(1'b1, 0, acc);
    check_eq("ovf_accept", w_accept, 0);
    check_eq("ovf_gray", wptr_gray, 4'b1100);
    check_eq("ovf_level", wlevel, DEPTH);
    check_eq("ovf_waddr", waddr, 0);

    // Drain one: full must hold for two edges and drop on the third.
    cycle(1'b0, 1, acc);
    check_eq("drain_e1_full", full, 1);
    cycle(1'b0, 1, acc);
    check_eq("drain_e2_full", full, 1);
    cycle(1'b0, 1, acc);
    check_eq("drain_e3_full", full, 0);
    check_eq("drain_e3_level", wlevel, 7);

    // Refill, then hold w_en while the reader frees a slot.
    cycle(1'b1, 1, acc);
    check_eq("refill_full", full, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 2, acc);
      check_eq("simul_accept", acc, (k == 3));
    end
    check_eq("simul_refull", full, 1);
    check_eq("simul_level", wlevel, DEPTH);

    // Asynchronous reset between edges while full.
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_clear();
    #1;
    reset = 1'b0;
    cycle(1'b1, 0, acc);
    check_eq("post_rst_accept", acc, 1);
    check_eq("post_rst_waddr", waddr, 1);

    // Wrap: reader trails the writer by two cycles.
    fresh_reset();
    prev1  = 0;
    prev2  = 0;
    prev_g = wptr_gray;
    check_eq("wrap_start", wptr_gray, wrap_seq[0]);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, prev2, acc);
      prev2 = prev1;
      prev1 = w_total;
      check_eq("wrap_seq", wptr_gray, wrap_seq[i+1]);
      check_eq("wrap_onebit", $countones(prev_g ^ wptr_gray), 1);
      check_eq("wrap_nofull", full, 0);
      prev_g = wptr_gray;
    end

    // Randomized traffic with a reader that never overtakes the writer.
    fresh_reset();
    for (int i = 0; i < 400; i++) begin
      if (r_total < w_total && ($urandom % 2) == 0) r_total++;
      prev_g = wptr_gray;
      cycle(($urandom % 4) != 0, r_total, acc);
      check_eq("rand_onebit", $countones(prev_g ^ wptr_gray) <= 1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
